// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one 4-bit ALU between two requesters. An idle sequencer samples
//   the two requests, picks a winner (round-robin on a tie), latches the
//   winner's operands, spends EXEC_CYCLES cycles executing, then presents
//   an 8-bit result tagged with the winner's ID for one DONE cycle.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   req0/op0/a0/b0     : requester 0 request, op code, operands
//   req1/op1/a1/b1     : requester 1 request, op code, operands
//   gnt[1:0]           : one-hot accept pulse (first EXEC cycle only)
//   busy               : high whenever the sequencer is not idle
//   res_valid          : one-cycle pulse qualifying res/res_id
//   res_id, res[7:0]   : owner and value of the last result (held)
module alu_share_arbiter #(
    parameter int EXEC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [2:0] op0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [2:0] op1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       res_valid,
    output logic       res_id,
    output logic [7:0] res
);

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } alu_req_t;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state, state_nxt;
    alu_req_t   req_q, req_sel;
    logic       winner, win_sel, prio;
    logic [3:0] cnt;
    logic [7:0] alu_out;
    logic       any_req;

    assign any_req = req0 | req1;
    assign busy    = (state != IDLE);

    // Winner selection: a lone requester always wins; on a tie prio decides.
    always_comb begin
        win_sel = req1;
        if (req0 && req1)
            win_sel = prio;
        req_sel = win_sel ? alu_req_t'{op1, a1, b1} : alu_req_t'{op0, a0, b0};
    end

    // ALU on the latched operands.
    always_comb begin
        alu_out = 8'h00;
        case (req_q.op)
            3'b000:         alu_out = {3'b000, {1'b0, req_q.a} + 5'd1};
            3'b001, 3'b010: alu_out = {3'b000, {1'b0, req_q.a} + {1'b0, req_q.b}};
            3'b011:         alu_out = {req_q.a | req_q.b, req_q.a ^ req_q.b};
            3'b100:         alu_out = {7'b0, |{req_q.b, req_q.a}};
            3'b101:         alu_out = {req_q.a, req_q.b};
            default:        alu_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= 2'b00;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res       <= 8'h00;
            prio      <= 1'b0;
            cnt       <= 4'd0;
            winner    <= 1'b0;
            req_q     <= '0;
        end else begin
            gnt       <= 2'b00;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        req_q  <= req_sel;
                        winner <= win_sel;
                        gnt    <= win_sel ? 2'b10 : 2'b01;
                        cnt    <= 4'(EXEC_CYCLES - 1);
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res       <= alu_out;
                        res_id    <= winner;
                        res_valid <= 1'b1;
                    end
                end
                DONE: prio <= ~winner;   // the other requester is favoured next
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: table vectors, hand sequences
// for contention / abort / EXEC_CYCLES=1, and a randomized run against a
// transaction-level model.
module tb_alu_share_arbiter;

    localparam int E = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 0, req1 = 0;
    logic [2:0] op0 = 0, op1 = 0;
    logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [1:0] gnt;
    logic       busy, res_valid, res_id;
    logic [7:0] res;

    // second instance built with EXEC_CYCLES=1
    logic       x_req0 = 0, x_req1 = 0;
    logic [2:0] x_op0 = 0, x_op1 = 0;
    logic [3:0] x_a0 = 0, x_b0 = 0, x_a1 = 0, x_b1 = 0;
    logic [1:0] x_gnt;
    logic       x_busy, x_res_valid, x_res_id;
    logic [7:0] x_res;

    int ncmp = 0;
    int nerr = 0;
    bit mprio = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.EXEC_CYCLES(E)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id), .res(res));

    alu_share_arbiter #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .req0(x_req0), .op0(x_op0), .a0(x_a0), .b0(x_b0),
        .req1(x_req1), .op1(x_op1), .a1(x_a1), .b1(x_b1),
        .gnt(x_gnt), .busy(x_busy), .res_valid(x_res_valid), .res_id(x_res_id), .res(x_res));

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       id;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU from the op table, plain integer arithmetic.
    function automatic int alu_model(input int op, input int a, input int b);
        case (op)
            0:       return a + 1;
            1, 2:    return a + b;
            3:       return (a | b) * 16 + (a ^ b);
            4:       return (a != 0 || b != 0) ? 1 : 0;
            5:       return a * 16 + b;
            default: return 0;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mprio = 0;
    endtask

    // One full transaction from request to idle; exp_r0/exp_r1 are the
    // expected result if requester 0 / 1 wins.
    task automatic txn(input bit r0, input bit r1,
                       input logic [2:0] o0, input logic [3:0] x0, input logic [3:0] y0,
                       input logic [2:0] o1, input logic [3:0] x1, input logic [3:0] y1,
                       input int exp_r0, input int exp_r1, input string tag);
        int n;
        int w;
        int er;
        req0 = r0; op0 = o0; a0 = x0; b0 = y0;
        req1 = r1; op1 = o1; a1 = x1; b1 = y1;
        w  = (r0 && r1) ? int'(mprio) : (r0 ? 0 : 1);
        er = w ? exp_r1 : exp_r0;
        n = 0;
        do begin step(); n++; end while (gnt == 2'b00 && n < 8);
        chk({tag, " gnt"}, int'(gnt), w ? 2 : 1);
        chk({tag, " busy"}, int'(busy), 1);
        // operands are free to change once granted
        req0 = 0; req1 = 0;
        op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
        op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        n = 0;
        while (!res_valid && n < 16) begin step(); n++; end
        chk({tag, " latency"}, n, E);
        chk({tag, " res"}, int'(res), er);
        chk({tag, " res_id"}, int'(res_id), w);
        step();
        chk({tag, " valid_drop"}, int'(res_valid), 0);
        chk({tag, " idle"}, int'(busy), 0);
        chk({tag, " res_hold"}, int'(res), er);
        mprio = (w == 0);
    endtask

    initial begin
        int g[3];
        int gc[3];
        int k;
        int n;
        int r;

        vt[0] = '{3'b001, 4'h9, 4'h8, 1'b0, 8'h11};
        vt[1] = '{3'b011, 4'h5, 4'h3, 1'b1, 8'h76};
        vt[2] = '{3'b101, 4'h3, 4'hA, 1'b1, 8'h3A};
        vt[3] = '{3'b000, 4'hF, 4'h0, 1'b1, 8'h10};
        vt[4] = '{3'b100, 4'h0, 4'h0, 1'b0, 8'h00};
        vt[5] = '{3'b100, 4'h0, 4'h4, 1'b0, 8'h01};
        vt[6] = '{3'b110, 4'h7, 4'h7, 1'b0, 8'h00};
        vt[7] = '{3'b111, 4'hF, 4'hF, 1'b1, 8'h00};
        vt[8] = '{3'b010, 4'hF, 4'hF, 1'b0, 8'h1E};
        vt[9] = '{3'b000, 4'h7, 4'h2, 1'b0, 8'h08};

        do_reset();
        chk("rst gnt", int'(gnt), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst res_valid", int'(res_valid), 0);
        chk("rst res_id", int'(res_id), 0);
        chk("rst res", int'(res), 0);

        for (int i = 0; i < 10; i++)
            txn(!vt[i].id, vt[i].id, vt[i].op, vt[i].a, vt[i].b,
                vt[i].op, vt[i].a, vt[i].b, int'(vt[i].exp), int'(vt[i].exp),
                $sformatf("vec%0d", i));

        // Both held from reset: grants alternate, E+2 cycles apart.
        do_reset();
        req0 = 1; req1 = 1;
        k = 0; n = 0;
        while (k < 3 && n < 40) begin
            step(); n++;
            if (gnt != 2'b00) begin g[k] = int'(gnt); gc[k] = n; k++; end
        end
        chk("rr count", k, 3);
        chk("rr gnt0", g[0], 1);
        chk("rr gnt1", g[1], 2);
        chk("rr gnt2", g[2], 1);
        chk("rr gap01", gc[1] - gc[0], E + 2);
        chk("rr gap12", gc[2] - gc[1], E + 2);
        req0 = 0; req1 = 0;
        n = 0;
        while (busy && n < 16) begin step(); n++; end
        chk("rr drain", int'(busy), 0);
        mprio = 1;

        // Abort in the second EXEC cycle.
        req0 = 1; op0 = 3'b001; a0 = 4'h1; b0 = 4'h1;
        n = 0;
        do begin step(); n++; end while (gnt == 2'b00 && n < 8);
        chk("abort gnt", int'(gnt), 1);
        req0 = 0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mprio = 0;
        chk("abort valid", int'(res_valid), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort res", int'(res), 0);
        chk("abort gnt0", int'(gnt), 0);
        k = 0;
        for (int i = 0; i < 4; i++) begin step(); if (res_valid) k++; end
        chk("abort no_result", k, 0);
        txn(1, 1, 3'b101, 4'h1, 4'h2, 3'b101, 4'h3, 4'h4, 8'h12, 8'h34, "post_abort_tie");
        txn(0, 1, 3'b000, 4'h0, 4'h0, 3'b001, 4'h8, 4'h8, 0, 8'h10, "post_abort_r1");

        // A request raised and dropped while busy is never granted.
        req1 = 1; op1 = 3'b101; a1 = 4'h6; b1 = 4'h9;
        n = 0;
        do begin step(); n++; end while (gnt == 2'b00 && n < 8);
        chk("drop gnt", int'(gnt), 2);
        req1 = 0; req0 = 1;
        step();
        req0 = 0;
        k = 0;
        for (int i = 0; i < 8; i++) begin step(); if (gnt != 2'b00) k++; end
        chk("drop no_gnt", k, 0);
        chk("drop res", int'(res), 8'h69);
        mprio = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro0, ro1;
            logic [3:0] ra0, rb0, ra1, rb1;
            bit rq0, rq1;
            r = $urandom_range(2, 0);
            rq0 = (r != 1); rq1 = (r != 0);
            ro0 = 3'($urandom); ra0 = 4'($urandom); rb0 = 4'($urandom);
            ro1 = 3'($urandom); ra1 = 4'($urandom); rb1 = 4'($urandom);
            txn(rq0, rq1, ro0, ra0, rb0, ro1, ra1, rb1,
                alu_model(ro0, ra0, rb0), alu_model(ro1, ra1, rb1),
                $sformatf("rnd%0d", i));
        end

        // EXEC_CYCLES=1 instance.
        x_req0 = 1; x_op0 = 3'b001; x_a0 = 4'hF; x_b0 = 4'hF;
        step();
        chk("e1 gnt", int'(x_gnt), 1);
        x_req0 = 0; x_a0 = 4'h0;
        step();
        chk("e1 valid", int'(x_res_valid), 1);
        chk("e1 res", int'(x_res), 8'h1E);
        chk("e1 res_id", int'(x_res_id), 0);
        step();
        chk("e1 valid_drop", int'(x_res_valid), 0);
        chk("e1 idle", int'(x_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
